// File: rtl/lcd_cmd_sequencer.sv
// Nios II multi-cycle custom instruction driving an 8-bit write-only HD44780 LCD.
// Runs the power-on init sequence after reset, then writes one CPU byte per instruction.
//
// state    | meaning
// PWR_WAIT | power-up delay after reset
// LOAD     | latch RS/D for the next write
// SETUP    | RS/D settling, EN low
// EN_HI    | EN strobe high
// HOLD     | RS/D held, EN low
// EXEC     | LCD execution wait
// IDLE     | init complete, waiting for a request
// DONE     | one-cycle completion pulse to the CPU
module lcd_cmd_sequencer #(
  parameter int T_POWERUP = 750000,
  parameter int T_SETUP   = 3,
  parameter int T_PW      = 25,
  parameter int T_HOLD    = 3,
  parameter int T_EXEC    = 2000,
  parameter int T_LONG    = 82000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        start,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic        done,
  output logic [31:0] result,
  output logic        ready,
  output logic        LCD_RS,
  output logic        LCD_RW,
  output logic        LCD_EN,
  output logic [7:0]  LCD_D
);
  localparam int CMAX = (T_POWERUP > T_LONG) ? T_POWERUP : T_LONG;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [2:0] INIT_LAST = 3'd5;

  typedef enum logic [2:0] {PWR_WAIT, LOAD, SETUP, EN_HI, HOLD, EXEC, IDLE, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt, cnt_last;
  logic          tc;
  logic [2:0]    init_idx;
  logic          req_pend;
  logic [8:0]    req_data;
  logic [7:0]    rom_byte;
  logic          rom_long;
  logic          exec_long;
  logic          unused_bits;

  assign unused_bits = ^{datab, dataa[31:9]};
  assign LCD_RW      = 1'b0;

  always_comb begin
    rom_byte = 8'h06;
    rom_long = 1'b0;
    case (init_idx)
      3'd0:      begin rom_byte = 8'h38; rom_long = 1'b1; end
      3'd1, 3'd2: rom_byte = 8'h38;
      3'd3:      rom_byte = 8'h0C;
      3'd4:      begin rom_byte = 8'h01; rom_long = 1'b1; end
      default:   rom_byte = 8'h06;
    endcase
  end

  // clear (0x01) and home (0x02/0x03) commands need the long execution wait
  assign exec_long = ready ? (!req_data[8] && (req_data[7:2] == 6'd0) && (req_data[1:0] != 2'd0))
                           : rom_long;

  always_comb begin
    cnt_last = '0;
    case (state)
      PWR_WAIT: cnt_last = CW'(T_POWERUP - 1);
      SETUP:    cnt_last = CW'(T_SETUP - 1);
      EN_HI:    cnt_last = CW'(T_PW - 1);
      HOLD:     cnt_last = CW'(T_HOLD - 1);
      EXEC:     cnt_last = exec_long ? CW'(T_LONG - 1) : CW'(T_EXEC - 1);
      default:  cnt_last = '0;
    endcase
  end

  assign tc = (cnt == cnt_last);

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    LCD_EN    = 1'b0;
    case (state)
      PWR_WAIT: if (tc) state_nxt = LOAD;
      LOAD:     state_nxt = SETUP;
      SETUP:    if (tc) state_nxt = EN_HI;
      EN_HI: begin
        LCD_EN = 1'b1;
        if (tc) state_nxt = HOLD;
      end
      HOLD:     if (tc) state_nxt = EXEC;
      EXEC: begin
        if (tc) begin
          if (ready)                    state_nxt = DONE;
          else if (init_idx != INIT_LAST) state_nxt = LOAD;
          else if (req_pend)            state_nxt = LOAD;
          else                          state_nxt = IDLE;
        end
      end
      IDLE:     if (req_pend) state_nxt = LOAD;
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default:  state_nxt = PWR_WAIT;
    endcase
    cnt_nxt = (state_nxt != state || state == IDLE || state == DONE) ? '0 : cnt + CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= PWR_WAIT;
      cnt      <= '0;
      init_idx <= '0;
      req_pend <= 1'b0;
      req_data <= '0;
      ready    <= 1'b0;
      result   <= '0;
      LCD_RS   <= 1'b0;
      LCD_D    <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == LOAD) begin
        LCD_RS <= ready ? req_data[8]   : 1'b0;
        LCD_D  <= ready ? req_data[7:0] : rom_byte;
      end
      if (state == EXEC && tc && !ready) begin
        if (init_idx == INIT_LAST) ready    <= 1'b1;
        else                       init_idx <= init_idx + 3'd1;
      end
      // pending clears as DONE is entered, so a start during DONE is accepted
      if (state_nxt == DONE) begin
        result   <= {23'b0, req_data};
        req_pend <= 1'b0;
      end else if (start && clk_en && !req_pend) begin
        req_pend <= 1'b1;
        req_data <= dataa[8:0];
      end
    end
  end
endmodule
